// File: rtl/vth_read_detector.sv
// Read stage of the NVM channel model: offsets and hard-detects each programmed
// cell, Gray-decodes the level and accumulates symbol/bit errors per frame.
module vth_read_detector #(
  parameter int unsigned       FRAME_LEN = 1024,
  parameter logic signed [15:0] VREF1    = 16'sd4096,
  parameter logic signed [15:0] VREF2    = 16'sd5837,
  parameter logic signed [15:0] VREF3    = 16'sd7066
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cell_valid,
  input  logic [31:0] cell_word,
  input  logic [15:0] read_offset,
  input  logic        stats_ack,
  output logic        det_valid,
  output logic [1:0]  det_level,
  output logic        det_err,
  output logic        frame_done,
  output logic [31:0] sym_err_cnt,
  output logic [31:0] bit_err_cnt,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] acc_cnt;

  logic               s1_valid;
  logic signed [15:0] s1_v;
  logic [1:0]         s1_lvl;
  logic [1:0]         det_bits;

  logic               accept_c;
  logic               last_c;
  logic signed [16:0] sum_c;
  logic [1:0]         region_c;
  logic [1:0]         level_c;
  logic [1:0]         diff_c;

  // Pre-program Vth field travels with the word but plays no part in detection.
  logic unused_pre_vth;
  assign unused_pre_vth = ^cell_word[15:2];

  // A full frame stops acceptance even while the FSM is still draining in RUN.
  assign accept_c = (state == RUN) && cell_valid && (in_cnt != FRAME_CNT);
  assign last_c   = (state == RUN) && det_valid && (acc_cnt == LAST_CNT);

  assign sum_c = 17'($signed(cell_word[31:16])) + 17'($signed(read_offset));

  always_comb begin
    region_c = 2'd3;
    if (s1_v < VREF1)      region_c = 2'd0;
    else if (s1_v < VREF2) region_c = 2'd1;
    else if (s1_v < VREF3) region_c = 2'd2;
  end

  // Gray order of the programmed levels: 00, 10, 11, 01.
  always_comb begin
    level_c = 2'd0;
    case (region_c)
      2'd0: level_c = 2'd0;
      2'd1: level_c = 2'd2;
      2'd2: level_c = 2'd3;
      2'd3: level_c = 2'd1;
      default: level_c = 2'd0;
    endcase
  end

  assign diff_c = level_c ^ s1_lvl;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (last_c)    state_next = REPORT;
      REPORT:  if (stats_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= (state_next == REPORT);
      busy       <= (state_next == RUN);
    end
  end

  // S1: offset add with saturation to the signed 16-bit range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_v     <= '0;
      s1_lvl   <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_lvl <= cell_word[1:0];
        if (sum_c[16] != sum_c[15])
          s1_v <= sum_c[16] ? 16'sh8000 : 16'sh7FFF;
        else
          s1_v <= sum_c[15:0];
      end
    end
  end

  // S2: detection result and per-cell error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_valid <= 1'b0;
      det_level <= '0;
      det_err   <= 1'b0;
      det_bits  <= '0;
    end else begin
      det_valid <= s1_valid;
      if (s1_valid) begin
        det_level <= level_c;
        det_err   <= |diff_c;
        det_bits  <= diff_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt      <= '0;
      acc_cnt     <= '0;
      sym_err_cnt <= '0;
      bit_err_cnt <= '0;
    end else if (state == IDLE && start) begin
      in_cnt      <= '0;
      acc_cnt     <= '0;
      sym_err_cnt <= '0;
      bit_err_cnt <= '0;
    end else begin
      if (accept_c) in_cnt <= in_cnt + 32'd1;
      if (state == RUN && det_valid) begin
        acc_cnt     <= acc_cnt + 32'd1;
        sym_err_cnt <= sym_err_cnt + 32'(det_err);
        bit_err_cnt <= bit_err_cnt + 32'(det_bits[0]) + 32'(det_bits[1]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt <= '0;
    else if (cell_valid && !accept_c && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

endmodule

// File: doc/vth_read_detector.md
Name: vth_read_detector

Overview:
Downstream read stage of the NVM channel model, fed by the 2-bit/cell voltage programming stage. It takes each packed programmed-cell word, applies a signed read-voltage offset, and hard-detects the level against three read references. It reverses the Gray level mapping, compares the result with the written level, and accumulates symbol-error and bit-error counts over a frame of FRAME_LEN cells. At the end of each frame it reports the counts through a held-until-acknowledged handshake.

Parameters:
FRAME_LEN, 1024, number of cells per statistics frame (must be ≥1).
VREF1, 16'd4096, read reference 1 (2.0 V in Q.11), erased/state1 boundary.
VREF2, 16'd5837, read reference 2 (2.85 V).
VREF3, 16'd7066, read reference 3 (3.45 V).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse that begins a frame; accepted only in IDLE.
cell_valid  input  1  cell_word is valid this cycle.
cell_word  input  32  [31:16] programmed Vth (signed, Q.11); [15:2] pre-program Vth (ignored); [1:0] written level.
read_offset  input  16  signed Q.11 offset added to Vth before detection (retention/drift emulation); sampled with each cell.
stats_ack  input  1  consumer acknowledge for frame statistics.
det_valid  output  1  det_level is valid (one-cycle pulse per cell).
det_level  output  2  detected level.
det_err  output  1  det_level differs from the written level (qualified by det_valid).
frame_done  output  1  frame statistics valid; held until acknowledged.
sym_err_cnt  output  32  symbol errors in the completed frame.
bit_err_cnt  output  32  bit errors in the completed frame.
drop_cnt  output  16  cells dropped while not in RUN; saturates at 16'hFFFF.
busy  output  1  high in the RUN state.

Behaviour:
- Reset: all outputs are 0, the FSM enters IDLE, and pipeline valids are cleared. Reset asserted mid-frame discards the partial counts.
- FSM states are IDLE, RUN and REPORT.
- IDLE: start moves the FSM to RUN and clears the cell counter, sym_err_cnt, bit_err_cnt and frame_done.
- RUN: cells are accepted while cell_valid=1. After the FRAME_LEN-th cell has been accepted and its errors accumulated, the FSM moves to REPORT.
- REPORT: frame_done=1 and the counts are frozen. stats_ack moves the FSM to IDLE and clears frame_done on the next edge.
- start in RUN or REPORT is ignored.
- A cell_valid in IDLE or REPORT is dropped and increments drop_cnt. drop_cnt is cleared only by reset.
- Pipeline stage S1 (edge after cell_valid): v = sext17(Vth) + sext17(read_offset), saturated to the range [-32768, 32767]; the written level is registered alongside.
- Pipeline stage S2: region = 0 if v<VREF1; 1 if v<VREF2; 2 if v<VREF3; else 3. The comparisons are signed.
- Region-to-level map: 0→0, 1→2, 2→3, 3→1 (Gray order 00,10,11,01).
- Timing: det_valid, det_level and det_err are registered at S2, i.e. det_valid rises 2 clocks after the cell_valid cycle. Back-to-back cells give back-to-back det_valid.
- Errors: sym error = (det_level != written level). Bit errors = popcount(det_level XOR written level), range 0..2.
- Accumulation: counters update on the edge after det_valid. frame_done rises 3 clocks after the last accepted cell_valid.
- Only cells accepted in RUN propagate to the error counters and to det_valid. Dropped cells produce no det_valid.
- A cell_valid that arrives in the same cycle as the RUN→REPORT transition is dropped.
- Counter width: 32-bit counters do not wrap within any legal FRAME_LEN (FRAME_LEN ≤ 2^30).
- Simultaneous stats_ack and start in REPORT: the ack is taken and start is ignored; a new start is needed in IDLE.

Test Plan:
- Reset, then start, FRAME_LEN=4, read_offset=0. Cells with Vth/level: 2867/0, 5222/2, 6451/3, 7680/1. Required: det_level 0,2,3,1; det_err all 0; frame_done after the last cell with sym=0, bit=0.
- read_offset=+700, cell 5222/level2 (v=5922 ≥ VREF2). Required: det_level=3, det_err=1, sym +1, bit +1.
- Cell 2867/level1 with offset 0. Required: det_level=0, sym +1, bit +1 (00 vs 01). Cell 7680/level0. Required: det_level=1, bit +1. Cell 6451/level0. Required: det_level=3, bit +2.
- Saturation: Vth=16'h7FF0 with offset=+1000. Required: v=32767 and det_level=1. Vth=16'h8000 with offset=-1. Required: v=-32768 and det_level=0.
- Drops: 3 cells in IDLE, then 2 cells during REPORT before stats_ack. Required: drop_cnt=5, counts unchanged, no det_valid for those cells.
- Async reset asserted mid-RUN after 2 of 4 cells. Required: immediate IDLE, all counts and frame_done 0. A subsequent full frame counts exactly 4 cells.
